uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO drained by a start/data/stop serializer.
// Optional build macro UART_TX_CRLF_EN appends an internally generated 8'h0a after every 8'h0d frame.
module uart_tx_fifo #(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     tx_pin,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CPB = (CLK_FRE * 1000000) / BAUD_RATE;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          push, pop;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          bit_end;
  logic          line, line_q, frame_q;
  logic          lf_pending;

  // Ready and level come only from the registered count.
  assign in_ready = (count < FULL_CNT);
  assign level    = count;
  assign push     = in_valid && in_ready;
  assign bit_end  = (cnt == CNT_LAST);

  // ---------------- FIFO ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // ---------------- serializer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    pop         = 1'b0;
    line        = 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // A pending LF outranks the FIFO head and consumes no entry.
        if (lf_pending) begin
          shreg_nxt = 8'h0a;
          state_nxt = START;
        end else if (count != '0) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          state_nxt = START;
        end
      end
      START: begin
        line    = 1'b0;
        cnt_nxt = bit_end ? '0 : cnt + 1'b1;
        if (bit_end) begin
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        line    = shreg[0];
        cnt_nxt = bit_end ? '0 : cnt + 1'b1;
        if (bit_end) begin
          shreg_nxt   = shreg >> 1;
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        line    = 1'b1;
        cnt_nxt = bit_end ? '0 : cnt + 1'b1;
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_TX_CRLF_EN
  logic cr_frame;
  logic frame_load;
  logic frame_done;

  assign frame_load = (state == IDLE) && (state_nxt == START);
  assign frame_done = (state == STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_frame   <= 1'b0;
      lf_pending <= 1'b0;
    end else begin
      if (frame_load) cr_frame <= (shreg_nxt == 8'h0d);
      if (frame_load && lf_pending)  lf_pending <= 1'b0;
      else if (frame_done && cr_frame) lf_pending <= 1'b1;
    end
  end
`else
  assign lf_pending = 1'b0;
`endif

  // Registered line: the pin trails the FSM by one cycle, and frame_q
  // keeps busy high until the last stop bit has actually left the pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q  <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      line_q  <= line;
      frame_q <= (state != IDLE);
    end
  end

  assign tx_pin = line_q;
  assign busy   = (count != '0) || (state != IDLE) || frame_q || lf_pending;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CPB = 4, DEPTH = 4) with a frame-level reference model and a line decoder.
module tb_uart_tx_fifo;
  localparam int CLK_FRE   = 1;
  localparam int BAUD_RATE = 250000;
  localparam int DEPTH     = 4;
  localparam int CPB       = 4;
  localparam int FRAME     = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx_pin, busy;
  logic [2:0] level;

  uart_tx_fifo #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_pin(tx_pin), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int max_lvl  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame popped at edge P drives the pin over edges P+1..P+FRAME; the next
  // pop may happen at P+FRAME+1 at the earliest.
  logic [7:0] mq[$];
  logic       have_frame = 1'b0;
  int         fstart = 0;
  logic [7:0] fbyte = 8'h00;
  logic       pending = 1'b0;
  logic       can_push;
  logic       exp_tx, exp_busy;
  int         k;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      have_frame = 1'b0;
      pending    = 1'b0;
    end else begin
      can_push = (mq.size() < DEPTH);
      if (!have_frame || cyc >= fstart + FRAME + 1) begin
        if (pending) begin
          fbyte = 8'h0a; pending = 1'b0; have_frame = 1'b1; fstart = cyc;
        end else if (mq.size() != 0) begin
          fbyte = mq.pop_front(); have_frame = 1'b1; fstart = cyc;
`ifdef UART_TX_CRLF_EN
          if (fbyte == 8'h0d) pending = 1'b1;
`endif
        end
      end
      if (in_valid && can_push) mq.push_back(in_data);
    end
    #1;
    exp_tx = 1'b1;
    if (have_frame && cyc > fstart && cyc <= fstart + FRAME) begin
      k = (cyc - fstart - 1) / CPB;
      if (k == 0)      exp_tx = 1'b0;
      else if (k <= 8) exp_tx = fbyte[k-1];
    end
    exp_busy = (mq.size() != 0) || (have_frame && cyc <= fstart + FRAME) || pending;
    chk("tx_pin", tx_pin, exp_tx);
    chk("busy", busy, exp_busy);
    chk("level", level, mq.size());
    chk("in_ready", in_ready, mq.size() < DEPTH);
    if (int'(level) > max_lvl) max_lvl = int'(level);
  end

  // ---------------- line decoder ----------------
  logic [7:0] rxq[$];
  int         rx_start[$];
  logic       rx_act = 1'b0;
  int         rx_s = 0;
  int         rx_off = 0;
  logic [7:0] rx_sh = 8'h00;

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) rx_act = 1'b0;
    else if (!rx_act) begin
      if (tx_pin === 1'b0) begin rx_act = 1'b1; rx_s = cyc; end
    end else begin
      rx_off = cyc - rx_s;
      for (int b = 1; b <= 8; b++) if (rx_off == CPB*b + 2) rx_sh[b-1] = tx_pin;
      if (rx_off == CPB*9 + 2) chk("stop_bit", tx_pin, 1);
      if (rx_off == FRAME - 1) begin
        rxq.push_back(rx_sh); rx_start.push_back(rx_s); rx_act = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int c);
    int g = 0;
    while (cyc < c && g < 5000) begin @(negedge clk); g++; end
  endtask

  task automatic push(input logic [7:0] b, output int e);
    int g = 0;
    in_valid = 1'b1; in_data = b;
    while (in_ready !== 1'b1 && g < 500) begin @(negedge clk); g++; end
    chk("push_accepted", in_ready, 1);
    e = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (busy !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
    chk("drain_busy_low", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  logic [9:0] pat = 10'b1101001010;  // A5 on the wire, start bit first
  logic [7:0] b2[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] exp_rx[$];
  int e[6];
  int n, e1, e2, rxn;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", tx_pin, 1);
    chk("reset_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_level", level, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte: start at N+2, pattern, busy falls at N+42
    push(8'hA5, n);
    wait_cyc(n + 1); chk("a5_idle_before_start", tx_pin, 1);
    wait_cyc(n + 2); chk("a5_start_at_n2", tx_pin, 0);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(n + 3 + CPB*i);
      chk("a5_pattern", tx_pin, pat[i]);
    end
    wait_cyc(n + 41); chk("a5_busy_at_n41", busy, 1);
    wait_cyc(n + 42); chk("a5_busy_at_n42", busy, 0);
    drain();

    // six bytes with in_valid held; the head pops at e0+1, so the 5th accept fills it
    for (int i = 0; i < 6; i++) begin
      push(b2[i], e[i]);
      if (i == 4) begin
        chk("burst_ready_low_when_full", in_ready, 0);
        chk("burst_level_full", level, 4);
      end
    end
    chk("burst_first5_consecutive", e[4] - e[0], 4);
    chk("burst_6th_after_pop", e[5] - e[0], 43);
    drain();

    // push coinciding with a pop at level 2
    push(8'h3C, e1);
    push(8'h5A, e2);
    push(8'hC3, e2);
    wait_cyc(e1 + 41);
    chk("pp_level_before", level, 2);
    in_valid = 1'b1; in_data = 8'h81;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_level_after", level, 2);
    drain();

    // reset during data bit 3 of the first of three queued bytes
    push(8'hF7, e1);
    push(8'h12, e2);
    push(8'h34, e2);
    wait_cyc(e1 + 19);
    chk("rst_bit3_before", tx_pin, 0);
    rxn = rxq.size();
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_high", tx_pin, 1);
    chk("rst_level_zero", level, 0);
    chk("rst_busy_low", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_no_output", rxq.size(), rxn);
    chk("rst_line_idle", tx_pin, 1);
    push(8'h96, n);
    drain();
    chk("rst_new_frame_count", rxq.size(), rxn + 1);

    // CR followed by a letter
    push(8'h0d, n);
    push(8'h41, n);
    drain();

    exp_rx = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
               8'h3C, 8'h5A, 8'hC3, 8'h81, 8'h96, 8'h0d};
`ifdef UART_TX_CRLF_EN
    exp_rx.push_back(8'h0a);
`endif
    exp_rx.push_back(8'h41);
    chk("rx_count", rxq.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rxq.size(); i++) chk("rx_byte", rxq[i], exp_rx[i]);
    for (int i = 1; i < 6 && i + 1 < rx_start.size(); i++)
      chk("burst_frame_spacing", rx_start[i+1] - rx_start[i], FRAME + 1);
    chk("level_max_le_depth", max_lvl <= DEPTH, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
